kofn_detector_pipe: RTL and testbench

- Parametrised, pipelined successor to the 3-input pair/triple (2-of-3) detector.
- Each accepted sample is an N-bit vector; the block counts its set bits, compares the count against a runtime threshold K, and tracks consecutive hits.
- Asserts a persistent detect flag after PERSIST consecutive hitting samples.
- Sits between a sample producer and consumer; latency-insensitive val/rdy interfaces on both sides.

---
 rtl/kofn_detector_pipe_if.sv | 30 +++
 rtl/kofn_detector_pipe.sv | 84 ++++++++
 tb/tb_kofn_detector_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/kofn_detector_pipe_if.sv
// Sample-in / record-out handshake bundle for kofn_detector_pipe.
// The producer/consumer side uses master; the detector uses slave.
interface kofn_detector_pipe_if #(
    parameter int N       = 8,
    parameter int PERSIST = 3,
    parameter int CW      = $clog2(N + 1),
    parameter int SW      = $clog2(PERSIST + 1)
);
    logic          in_val;
    logic          in_rdy;
    logic [N-1:0]  in_bits;
    logic [CW-1:0] thresh;
    logic          clear;
    logic          out_val;
    logic          out_rdy;
    logic [CW-1:0] out_count;
    logic          out_hit;
    logic [SW-1:0] out_streak;
    logic          out_detect;

    modport master (
        output in_val, in_bits, thresh, clear, out_rdy,
        input  in_rdy, out_val, out_count, out_hit, out_streak, out_detect
    );

    modport slave (
        input  in_val, in_bits, thresh, clear, out_rdy,
        output in_rdy, out_val, out_count, out_hit, out_streak, out_detect
    );
endinterface

// File: rtl/kofn_detector_pipe.sv
// Two-stage K-of-N popcount detector with a saturating consecutive-hit streak.
// S1 holds popcount/hit; S2 is the output register and owns the streak.
module kofn_detector_pipe #(
    parameter int N       = 8,
    parameter int PERSIST = 3,
    parameter int CW      = $clog2(N + 1),
    parameter int SW      = $clog2(PERSIST + 1)
) (
    input logic                clk,
    input logic                rst_n,
    kofn_detector_pipe_if.slave bus
);
    logic          s1_val, s1_hit;
    logic [CW-1:0] s1_count;
    logic          s2_val, s2_hit, s2_detect;
    logic [CW-1:0] s2_count;
    logic [SW-1:0] s2_streak, streak;

    logic          s1_adv, s2_adv, in_rdy;
    logic [CW-1:0] pc;
    logic          pc_hit;
    logic [SW-1:0] base, new_streak;

    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + CW'(bus.in_bits[i]);
    end

    // thresh can exceed N inside CW bits, so that case naturally never hits
    assign pc_hit = (pc >= bus.thresh);

    assign s2_adv = !s2_val || bus.out_rdy;
    assign s1_adv = s1_val && s2_adv;
    assign in_rdy = !s1_val || s2_adv;

    assign base       = bus.clear ? '0 : streak;
    assign new_streak = !s1_hit                ? '0 :
                        (base >= SW'(PERSIST)) ? SW'(PERSIST) :
                                                 base + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val   <= 1'b0;
            s1_count <= '0;
            s1_hit   <= 1'b0;
        end else if (in_rdy) begin
            s1_val <= bus.in_val;
            if (bus.in_val) begin
                s1_count <= pc;
                s1_hit   <= pc_hit;
            end
        end
    end

    // Streak only moves on a transfer; a lone clear zeroes it without touching S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_val    <= 1'b0;
            s2_count  <= '0;
            s2_hit    <= 1'b0;
            s2_streak <= '0;
            s2_detect <= 1'b0;
            streak    <= '0;
        end else begin
            if (s2_adv) s2_val <= s1_val;
            if (s1_adv) begin
                s2_count  <= s1_count;
                s2_hit    <= s1_hit;
                s2_streak <= new_streak;
                s2_detect <= (new_streak == SW'(PERSIST));
                streak    <= new_streak;
            end else if (bus.clear) begin
                streak <= '0;
            end
        end
    end

    assign bus.in_rdy     = in_rdy;
    assign bus.out_val    = s2_val;
    assign bus.out_count  = s2_count;
    assign bus.out_hit    = s2_hit;
    assign bus.out_streak = s2_streak;
    assign bus.out_detect = s2_detect;
endmodule

// File: tb/tb_kofn_detector_pipe.sv
// Bench for kofn_detector_pipe: queue-based scoreboard plus directed corner cases.
module tb_kofn_detector_pipe;
    logic clk, rst_n;
    int   total = 0, bad = 0;

    kofn_detector_pipe_if #(.N(8), .PERSIST(3)) bus ();
    kofn_detector_pipe_if #(.N(3), .PERSIST(3)) b3 ();

    kofn_detector_pipe #(.N(8), .PERSIST(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    kofn_detector_pipe #(.N(3), .PERSIST(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int cnt; int hit; int stk; int det; } rec_t;
    rec_t exp_q[$];
    int   log_cnt[$], log_hit[$], log_stk[$], log_det[$];
    int   stim_b[$], stim_t[$];
    int   m_streak = 0;
    bit   sb_en = 0;
    bit   stalled;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: each accepted sample extends or breaks the run, in acceptance order
    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (bus.in_val && bus.in_rdy) begin
                rec_t r;
                r.cnt = $countones(bus.in_bits);
                r.hit = (r.cnt >= int'(bus.thresh)) ? 1 : 0;
                m_streak = r.hit ? ((m_streak + 1 > 3) ? 3 : m_streak + 1) : 0;
                r.stk = m_streak;
                r.det = (m_streak == 3) ? 1 : 0;
                exp_q.push_back(r);
            end
            if (bus.out_val && bus.out_rdy) begin
                if (exp_q.size() == 0) chk("sb_extra", 1, 0);
                else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    chk("sb_cnt", int'(bus.out_count), e.cnt);
                    chk("sb_hit", int'(bus.out_hit), e.hit);
                    chk("sb_stk", int'(bus.out_streak), e.stk);
                    chk("sb_det", int'(bus.out_detect), e.det);
                end
                log_cnt.push_back(int'(bus.out_count));
                log_hit.push_back(int'(bus.out_hit));
                log_stk.push_back(int'(bus.out_streak));
                log_det.push_back(int'(bus.out_detect));
            end
        end
    end

    task automatic do_reset();
        sb_en = 0;
        bus.in_val = 1'b0; bus.clear = 1'b0; bus.out_rdy = 1'b1;
        b3.in_val = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        log_cnt.delete(); log_hit.delete(); log_stk.delete(); log_det.delete();
        m_streak = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // bp: 0 = out_rdy high, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random
    task automatic stream(input int bp);
        int          sent = 0, cyc = 0;
        logic [5:0]  pat = 6'b101001;
        stalled = 0;
        sb_en = 1;
        while ((sent < stim_b.size() || exp_q.size() != 0) && cyc < 3000) begin
            bus.in_val = (sent < stim_b.size());
            if (sent < stim_b.size()) begin
                bus.in_bits = 8'(stim_b[sent]);
                bus.thresh  = 4'(stim_t[sent]);
            end
            bus.out_rdy = (bp == 0) ? 1'b1 : (bp == 1) ? pat[cyc % 6] : 1'($urandom % 2);
            @(negedge clk);
            if (bus.in_val && !bus.in_rdy) stalled = 1;
            if (bus.in_val && bus.in_rdy) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b1;
        if (cyc >= 3000) chk("stream_timeout", 0, 1);
        sb_en = 0;
    endtask

    initial begin
        int maj[8]  = '{0, 0, 0, 1, 0, 1, 1, 1};
        int stk3[8] = '{0, 0, 0, 1, 0, 1, 2, 3};
        int ref_stk[$];
        int cv[10], cc[10];

        rst_n = 1'b1;
        bus.in_val = 1'b0; bus.in_bits = '0; bus.thresh = '0; bus.clear = 1'b0; bus.out_rdy = 1'b1;
        b3.in_val = 1'b0; b3.in_bits = '0; b3.thresh = 2'd2; b3.clear = 1'b0; b3.out_rdy = 1'b1;

        // Async reset asserted mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_val", int'(bus.out_val), 0);
        chk("rst_cnt", int'(bus.out_count), 0);
        chk("rst_det", int'(bus.out_detect), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_inrdy", int'(bus.in_rdy), 1);
        do_reset();

        // Mid-stream reset: fill both stages under backpressure, then drop rst_n
        bus.in_val = 1'b1; bus.in_bits = 8'hFF; bus.thresh = 4'd0; bus.out_rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("full_inrdy", int'(bus.in_rdy), 0);
        chk("full_val", int'(bus.out_val), 1);
        chk("full_cnt", int'(bus.out_count), 8);
        #2 rst_n = 1'b0;
        bus.in_val = 1'b0;
        #1;
        chk("mid_rst_val", int'(bus.out_val), 0);
        chk("mid_rst_cnt", int'(bus.out_count), 0);
        chk("mid_rst_stk", int'(bus.out_streak), 0);
        chk("mid_rst_det", int'(bus.out_detect), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        #1 chk("mid_rst_inrdy", int'(bus.in_rdy), 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_rst_flushed", int'(bus.out_val), 0);

        // 2-of-3 majority on the N=3 instance, two-cycle latency
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b3.in_val  = (i < 8);
            b3.in_bits = 3'(i);
            @(negedge clk);
            if (i >= 2) begin
                chk("maj_val", int'(b3.out_val), 1);
                chk("maj_cnt", int'(b3.out_count), $countones(3'(i - 2)));
                chk("maj_hit", int'(b3.out_hit), maj[i-2]);
                chk("maj_stk", int'(b3.out_streak), stk3[i-2]);
                chk("maj_det", int'(b3.out_detect), (i == 9) ? 1 : 0);
            end
            @(posedge clk); #1;
        end
        b3.in_val = 1'b0;

        // Persistence and saturation
        do_reset();
        stim_b = '{8'h0F, 8'hFF, 8'h1F, 8'hF0, 8'h01};
        stim_t = '{4, 4, 4, 4, 4};
        stream(0);
        chk("pers_n", log_stk.size(), 5);
        if (log_stk.size() == 5) begin
            chk("pers_stk0", log_stk[0], 1); chk("pers_stk1", log_stk[1], 2);
            chk("pers_stk2", log_stk[2], 3); chk("pers_stk3", log_stk[3], 3);
            chk("pers_stk4", log_stk[4], 0);
            chk("pers_det1", log_det[1], 0); chk("pers_det2", log_det[2], 1);
            chk("pers_det3", log_det[3], 1); chk("pers_det4", log_det[4], 0);
        end

        // Backpressure: same six samples unstalled then with a stall pattern
        do_reset();
        stim_b = '{8'hFF, 8'h0F, 8'h03, 8'hF7, 8'h7E, 8'hFF};
        stim_t = '{4, 4, 4, 4, 4, 4};
        stream(0);
        ref_stk = log_stk;
        do_reset();
        stream(1);
        chk("bp_stall_seen", int'(stalled), 1);
        chk("bp_n", log_stk.size(), 6);
        if (log_stk.size() == 6 && ref_stk.size() == 6)
            for (int i = 0; i < 6; i++) chk("bp_stk_same", log_stk[i], ref_stk[i]);

        // Threshold corners
        do_reset();
        stim_b = '{8'h00, 8'hFF, 8'hFF};
        stim_t = '{0, 8, 9};
        stream(0);
        chk("thr_n", log_hit.size(), 3);
        if (log_hit.size() == 3) begin
            chk("thr0_hit", log_hit[0], 1);
            chk("thr8_cnt", log_cnt[1], 8);
            chk("thr8_hit", log_hit[1], 1);
            chk("thr9_hit", log_hit[2], 0);
        end

        // Randomized traffic with random backpressure
        do_reset();
        stim_b.delete(); stim_t.delete();
        for (int i = 0; i < 200; i++) begin
            stim_b.push_back(int'($urandom_range(0, 255)));
            stim_t.push_back(int'($urandom_range(0, 9)));
        end
        stream(2);
        chk("rand_n", log_stk.size(), 200);

        // Clear: collision with a transfer, then clear while idle
        do_reset();
        bus.in_bits = 8'hFF; bus.thresh = 4'd4; bus.out_rdy = 1'b1;
        cv = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        cc = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            bus.in_val = cv[i][0];
            bus.clear  = cc[i][0];
            @(negedge clk);
            if (i == 2) chk("clr_stk_a", int'(bus.out_streak), 1);
            if (i == 3) chk("clr_stk_b", int'(bus.out_streak), 2);
            if (i == 4) chk("clr_collide", int'(bus.out_streak), 1);
            if (i == 6) begin
                chk("clr_idle_val", int'(bus.out_val), 0);
                chk("clr_idle_hold", int'(bus.out_streak), 1);
            end
            if (i == 8) begin
                chk("clr_after_val", int'(bus.out_val), 1);
                chk("clr_after_stk", int'(bus.out_streak), 1);
            end
            @(posedge clk); #1;
        end
        bus.in_val = 1'b0;
        bus.clear  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
